hcsr04_ranger: RTL
==================

// Module: hcsr04_ranger
// PURPOSE
//  Upstream stage of the distance path: drives the HC-SR04 trig pin and times the echo pulse.
//  Emits one 12-bit echo width in us per measurement period, with a 1-cycle valid strobe.
//  Output feeds the moving-average smoother, which feeds the LED bar decoder.
//  Replaces the free-running uclk/counter logic with a single-clock FSM plus a timeout.
// PARAMETERS
//  TICKS_PER_US  40     clk cycles per microsecond (40 MHz clk)
//  TRIG_US       20     trig high time, us (10 us is unreliable on our sensor)
//  PERIOD_US     60000  measurement period, us; trig starts each period
//  TIMEOUT_US    30000  us after trig rise with no completed echo -> timeout
//  MAX_US        3552   saturation value for sample (2 ft range); must be <= 4095
// PORTS
//  clk           in   1   system clock, 40 MHz
//  reset         in   1   asynchronous, active-high reset
//  echo          in   1   raw sensor echo pin, asynchronous to clk
//  trig          out  1   sensor trigger pin
//  sample        out  12  last echo width, us, saturated at MAX_US
//  sample_valid  out  1   1-cycle pulse when sample updates
//  timeout       out  1   1 = last sample was produced by timeout
// BEHAVIOUR
//  - echo passes a 2-flop synchronizer (echo_s). Edge detection uses echo_s and its 1-cycle delay.
//  - us tick: prescaler counts 0..TICKS_PER_US-1; tick is high for one clk when it reads TICKS_PER_US-1.
//  - period counter: in us, 0..PERIOD_US-1, advances on tick. A trigger starts on every wrap to 0.
//  - Reset values: trig=0, sample=0, sample_valid=0, timeout=0, state=IDLE, prescaler=0.
//    The period counter resets to PERIOD_US-1, so the first trigger starts on the first tick after reset.
//  - FSM:
//    IDLE -> TRIG on period wrap.
//    TRIG: trig=1. Goes to WAIT after TRIG_US ticks; trig=0 from then on.
//    WAIT: on echo_s rising edge, width:=0 and go to MEAS.
//      An echo already high on entry is not a rising edge.
//    MEAS: width+1 on each tick, saturating at MAX_US. On echo_s falling edge go to DONE.
//    DONE: for 1 cycle, sample<=width, timeout<=0, sample_valid=1, then go to IDLE.
//    WAIT/MEAS: if the period counter reaches TIMEOUT_US, sample<=MAX_US, timeout<=1,
//      sample_valid=1 for 1 cycle, then go to IDLE.
//    IDLE ignores echo until the next period wrap. Exactly one sample_valid per period.
//  - Latency: sample_valid asserts 4 clk after the echo pin falls (2 sync, 1 edge, 1 DONE).
//  - Quantisation: width is counted in whole ticks, so accuracy is +/-1 us.
//  - sample and timeout hold their value between strobes.
//  - A period wrap while in WAIT/MEAS cannot occur, because TIMEOUT_US < PERIOD_US is required.
//  - A falling edge and a timeout in the same cycle: the falling edge wins (normal sample).
//  - Reset mid-operation: all outputs return to reset values at once and trig drops.
//    No strobe is issued for the aborted measurement.
// CONFIGURATION
//  RANGER_ECHO_DEGLITCH_EN defined:
//    echo_s is replaced by a filtered echo that changes only after 4 consecutive equal
//    synchronized samples. Pulses shorter than 4 clk are ignored. Latency rises to 8 clk.
//  Not defined: the plain 2-flop synchronized echo is used; latency is 4 clk.
// TESTING
//  1. Release reset -> trig rises within 40 clk and stays high for exactly 800 clk. sample=0, valid=0.
//  2. Echo high for 1000 us, starting 100 us after trig falls -> one valid pulse,
//     sample=1000+/-1, timeout=0.
//  3. Echo high for 5000 us -> sample=3552 (saturated), timeout=0, one valid pulse at the falling edge.
//  4. Echo never rises -> valid at 30000 us after trig rise, sample=3552, timeout=1.
//     Next trig comes 60000 us after the previous one.
//  5. Assert reset at 500 us into a measurement -> trig=0, sample=0, no valid.
//     After release, a new trigger starts and a 700 us echo gives sample=700+/-1.
//  6. 2-clk echo glitch in WAIT, then a real 300 us echo:
//     with RANGER_ECHO_DEGLITCH_EN, sample=300+/-1;
//     without it, sample in {0,1} from the glitch.

Source files
------------

// File: rtl/hcsr04_ranger_if.sv
// hcsr04_ranger_if: sensor-side signal bundle for the HC-SR04 ranger.
// master = ranger (drives trig and the sample outputs), slave = sensor/consumer side.
interface hcsr04_ranger_if;
    logic        echo;
    logic        trig;
    logic [11:0] sample;
    logic        sample_valid;
    logic        timeout;

    modport master (
        input  echo,
        output trig,
        output sample,
        output sample_valid,
        output timeout
    );

    modport slave (
        output echo,
        input  trig,
        input  sample,
        input  sample_valid,
        input  timeout
    );
endinterface

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: HC-SR04 trigger generator and echo-width timer.
// One trigger per measurement period; one 12-bit echo width (us, saturated at
// MAX_US) per period with a 1-cycle strobe, or MAX_US with timeout=1 if no
// echo completes within TIMEOUT_US of the trigger rise.
// Optional: define RANGER_ECHO_DEGLITCH_EN to filter echo pulses shorter than 4 clk.
module hcsr04_ranger #(
    parameter int unsigned TICKS_PER_US = 40,
    parameter int unsigned TRIG_US      = 20,
    parameter int unsigned PERIOD_US    = 60000,
    parameter int unsigned TIMEOUT_US   = 30000,
    parameter int unsigned MAX_US       = 3552
) (
    input  logic              clk,
    input  logic              reset,
    hcsr04_ranger_if.master   bus
);

    localparam int unsigned PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
    localparam int unsigned PER_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;
    localparam int unsigned TRG_W = $clog2(TRIG_US + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT,
        ST_MEAS,
        ST_DONE
    } state_t;

    logic             echo_m_q, echo_sy_q, echo_d_q;
    logic             echo_s, echo_rise, echo_fall;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [PER_W-1:0] period_q, period_d;
    logic             tick, wrap, at_timeout;
    state_t           state_q;
    logic [TRG_W-1:0] trig_cnt_q;
    logic [11:0]      width_q, sample_q;
    logic             trig_q, valid_q, timeout_q;

    // Two-flop synchronizer for the asynchronous echo pin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_m_q  <= 1'b0;
            echo_sy_q <= 1'b0;
        end else begin
            echo_m_q  <= bus.echo;
            echo_sy_q <= echo_m_q;
        end
    end

`ifdef RANGER_ECHO_DEGLITCH_EN
    logic       echo_f_q;
    logic [1:0] flt_cnt_q;

    // Filtered echo follows the synchronized level only after 4 consecutive agreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_f_q  <= 1'b0;
            flt_cnt_q <= '0;
        end else if (echo_sy_q == echo_f_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == 2'd3) begin
            echo_f_q  <= echo_sy_q;
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 2'd1;
        end
    end

    assign echo_s = echo_f_q;
`else
    assign echo_s = echo_sy_q;
`endif

    // One-cycle delayed echo for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) echo_d_q <= 1'b0;
        else       echo_d_q <= echo_s;
    end

    assign echo_rise  = echo_s & ~echo_d_q;
    assign echo_fall  = ~echo_s & echo_d_q;
    assign tick       = (pre_q == PRE_W'(TICKS_PER_US - 1));
    assign wrap       = tick && (period_q == PER_W'(PERIOD_US - 1));
    assign at_timeout = (period_q == PER_W'(TIMEOUT_US));

    // Next values of the microsecond prescaler and the period counter
    always_comb begin
        pre_d    = tick ? '0 : pre_q + PRE_W'(1);
        period_d = period_q;
        if (tick) begin
            period_d = (period_q == PER_W'(PERIOD_US - 1)) ? '0 : period_q + PER_W'(1);
        end
    end

    // Timebase registers; period starts at its last value so the first tick wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q    <= '0;
            period_q <= PER_W'(PERIOD_US - 1);
        end else begin
            pre_q    <= pre_d;
            period_q <= period_d;
        end
    end

    // Measurement FSM with registered trig/sample/strobe outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            trig_q     <= 1'b0;
            trig_cnt_q <= '0;
            width_q    <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wrap) begin
                        state_q    <= ST_TRIG;
                        trig_q     <= 1'b1;
                        trig_cnt_q <= '0;
                    end
                end
                ST_TRIG: begin
                    if (tick) begin
                        if (trig_cnt_q == TRG_W'(TRIG_US - 1)) begin
                            state_q <= ST_WAIT;
                            trig_q  <= 1'b0;
                        end else begin
                            trig_cnt_q <= trig_cnt_q + TRG_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (at_timeout) begin
                        sample_q  <= 12'(MAX_US);
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if (echo_rise) begin
                        width_q <= '0;
                        state_q <= ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    if (tick && (width_q != 12'(MAX_US))) begin
                        width_q <= width_q + 12'd1;
                    end
                    // A falling edge takes priority over a coincident timeout
                    if (echo_fall) begin
                        state_q <= ST_DONE;
                    end else if (at_timeout) begin
                        sample_q  <= 12'(MAX_US);
                        timeout_q <= 1'b1;
                        valid_q   <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    sample_q  <= width_q;
                    timeout_q <= 1'b0;
                    valid_q   <= 1'b1;
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.trig         = trig_q;
    assign bus.sample       = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.timeout      = timeout_q;

endmodule
